// File: rtl/mandelbrot_pixel_packer_pkg.sv
// Shared constants and types for the Mandelbrot pixel packer: raster defaults,
// packer states and the layout of a FIFO entry.
package mandelbrot_pixel_packer_pkg;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int PIX_W          = 4;
   localparam int FIFO_DATA_W    = 2 + 2 * PIX_W;

   typedef enum logic {
      PK_EVEN = 1'b0,
      PK_ODD  = 1'b1
   } pack_state_t;

   // One FIFO entry: {eol, sof, {odd-x pixel, even-x pixel}}
   typedef struct packed {
      logic                 eol;
      logic                 sof;
      logic [2*PIX_W-1:0]   data;
   } fifo_word_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mandelbrot_pixel_packer_if.sv
// Byte stream leaving the pixel packer: packed byte with frame/line sideband
// and a valid/ready handshake.
interface mandelbrot_pixel_packer_if;
   logic [7:0] out_data;
   logic       out_sof;
   logic       out_eol;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, out_sof, out_eol, out_valid, input out_ready);
   modport slave  (input out_data, out_sof, out_eol, out_valid, output out_ready);
endinterface

// File: rtl/mandelbrot_pixel_packer_sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module mandelbrot_pixel_packer_sync_fifo
   import mandelbrot_pixel_packer_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       level,
   output logic              full,
   output logic              empty
);

   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_cnt;
   logic [AW:0]       rd_cnt;
   logic              do_push;
   logic              do_pop;

   assign level   = wr_cnt - rd_cnt;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is forced to zero when empty so the stream reads clean after reset.
   assign rd_data = empty ? '0 : mem[rd_cnt[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (do_push) wr_cnt <= wr_cnt + 1'b1;
         if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_cnt[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/mandelbrot_pixel_packer.sv
// Packs 4-bit iteration buckets two per byte in raster order, tags frame/line
// starts and ends, and buffers the bytes for a valid/ready consumer.
//
// state   | meaning
// PK_EVEN | no nibble held; next pixel is even-x and gets stored
// PK_ODD  | even-x nibble held; next pixel completes the byte and pushes it
module mandelbrot_pixel_packer
   import mandelbrot_pixel_packer_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PIX_W-1:0]              pix_in,
   input  logic                          pix_valid,
   input  logic                          running,
   mandelbrot_pixel_packer_if.master     out_if,
   output logic [LVL_W-1:0]              fifo_level,
   output logic                          overflow,
   output logic                          frame_done
);

   localparam int XW = cnt_width(IMG_WIDTH);
   localparam int YW = cnt_width(IMG_HEIGHT);

   pack_state_t      state;
   pack_state_t      state_cur;
   pack_state_t      state_nxt;
   logic             running_q;
   logic             frame_start;
   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic [XW-1:0]    x_cur;
   logic [YW-1:0]    y_cur;
   logic             x_last;
   logic             y_last;
   logic [PIX_W-1:0] held;
   logic             hold_load;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   fifo_word_t       wr_word;
   fifo_word_t       head;
   logic [FIFO_DATA_W-1:0] head_bits;

   // A frame start takes effect in the same cycle, so a coincident pixel is (0,0).
   assign frame_start = running && !running_q;
   assign x_cur       = frame_start ? '0 : x;
   assign y_cur       = frame_start ? '0 : y;
   assign state_cur   = frame_start ? PK_EVEN : state;
   assign x_last      = (x_cur == XW'(IMG_WIDTH - 1));
   assign y_last      = (y_cur == YW'(IMG_HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= PK_EVEN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state_cur;
      if (pix_valid) state_nxt = (state_cur == PK_EVEN) ? PK_ODD : PK_EVEN;
   end

   always_comb begin
      hold_load = 1'b0;
      push      = 1'b0;
      if (pix_valid) begin
         hold_load = (state_cur == PK_EVEN);
         push      = (state_cur == PK_ODD);
      end
   end

   assign wr_word.eol  = x_last;
   assign wr_word.sof  = (y_cur == '0) && (x_cur == XW'(1));
   assign wr_word.data = {pix_in, held};

   always_ff @(posedge clk) begin
      if (reset) begin
         running_q  <= 1'b0;
         x          <= '0;
         y          <= '0;
         held       <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         running_q  <= running;
         frame_done <= pix_valid && x_last && y_last;
         if (pix_valid) begin
            x <= x_last ? '0 : x_cur + XW'(1);
            y <= x_last ? (y_last ? '0 : y_cur + YW'(1)) : y_cur;
         end else if (frame_start) begin
            x <= '0;
            y <= '0;
         end
         if (hold_load) held <= pix_in;
         if (frame_start)                    overflow <= 1'b0;
         else if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   assign pop = !fifo_empty && out_if.out_ready;

   mandelbrot_pixel_packer_sync_fifo #(
      .DATA_W (FIFO_DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (wr_word),
      .pop     (pop),
      .rd_data (head_bits),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head             = head_bits;
   assign out_if.out_data  = head.data;
   assign out_if.out_sof   = head.sof;
   assign out_if.out_eol   = head.eol;
   assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// Self-checking bench for the pixel packer on a 4x2 raster with a 4-entry FIFO.
module tb_mandelbrot_pixel_packer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] pix_in;
   logic       pix_valid;
   logic       running;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       frame_done;

   mandelbrot_pixel_packer_if bus ();

   mandelbrot_pixel_packer #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .FIFO_DEPTH (D)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .running    (running),
      .out_if     (bus),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pixel index within frame, held nibble, byte queue.
   int          m_p = 0;
   logic [3:0]  m_held = '0;
   logic [9:0]  m_q[$];
   bit          m_ovf = 0;
   bit          m_fd = 0;
   bit          m_prev_run = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_edge();
      bit         start;
      bit         pop;
      logic [9:0] b;
      if (reset) begin
         m_p = 0; m_q.delete(); m_ovf = 0; m_fd = 0; m_prev_run = 0;
         return;
      end
      start = running && !m_prev_run;
      pop   = (m_q.size() != 0) && bus.out_ready;
      m_prev_run = running;
      m_fd = 0;
      if (start) begin
         m_p = 0;
         m_ovf = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (pix_valid) begin
         if (m_p % 2 == 0) begin
            m_held = pix_in;
         end else begin
            b = {(m_p % W == W - 1), (m_p == 1), pix_in, m_held};
            if (m_q.size() < D) m_q.push_back(b);
            else m_ovf = 1;
         end
         m_fd = (m_p == W * H - 1);
         m_p = (m_p + 1) % (W * H);
      end
   endtask

   task automatic check_model();
      chk("out_valid", bus.out_valid, (m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("out_data", bus.out_data, m_q[0][7:0]);
         chk("out_sof",  bus.out_sof,  m_q[0][8]);
         chk("out_eol",  bus.out_eol,  m_q[0][9]);
      end
      chk("fifo_level", fifo_level, m_q.size());
      chk("overflow",   overflow,   m_ovf);
      chk("frame_done", frame_done, m_fd);
   endtask

   task automatic step(input logic pv, input logic [3:0] pin, input logic run,
                       input logic rdy, input logic rst);
      pix_valid     = pv;
      pix_in        = pin;
      running       = run;
      bus.out_ready = rdy;
      reset         = rst;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++)
         step(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   typedef struct {
      logic       pv;
      logic [3:0] pin;
      logic       run;
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic       es;
      logic       ee;
      logic       efd;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [7:0] exp_b[4];
      logic       run_r;
      int         rdy_pct;

      vecs[0] = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 8'h43, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 8'h65, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 8'h87, 1'b0, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

      pix_valid = 0; pix_in = 0; running = 0; bus.out_ready = 0; reset = 1;

      // Reset with random inputs
      do_reset();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data",  bus.out_data,  0);
      chk("rst_sof",   bus.out_sof,   0);
      chk("rst_eol",   bus.out_eol,   0);
      chk("rst_level", fifo_level,    0);
      chk("rst_ovf",   overflow,      0);
      chk("rst_fd",    frame_done,    0);

      // Full frame, consumer always ready
      step(0, 0, 0, 1, 0);
      foreach (vecs[i]) begin
         step(vecs[i].pv, vecs[i].pin, vecs[i].run, vecs[i].rdy, 1'b0);
         chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].ev);
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].ed);
            chk($sformatf("vec%0d_sof", i),  bus.out_sof,  vecs[i].es);
            chk($sformatf("vec%0d_eol", i),  bus.out_eol,  vecs[i].ee);
         end
         chk($sformatf("vec%0d_fd", i), frame_done, vecs[i].efd);
      end

      // Backpressure: five bytes into a four-entry FIFO
      exp_b[0] = 8'h21; exp_b[1] = 8'h43; exp_b[2] = 8'h65; exp_b[3] = 8'h87;
      do_reset();
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) step(1, 4'(i), 1, 0, 0);
      chk("bp_level", fifo_level, 4);
      chk("bp_ovf",   overflow,   1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp_data%0d", k), bus.out_data, exp_b[k]);
         step(0, 0, 1, 1, 0);
      end
      chk("bp_empty", bus.out_valid, 0);

      // Full FIFO with simultaneous pop and push
      do_reset();
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) step(1, 4'(i), 1, 0, 0);
      step(1, 4'hA, 1, 1, 0);
      chk("pp_level", fifo_level, 4);
      chk("pp_ovf",   overflow,   0);
      chk("pp_head",  bus.out_data, 8'h43);
      for (int k = 0; k < 4; k++) step(0, 0, 1, (k != 0), 0);
      chk("pp_last_data", bus.out_data, 8'hA9);
      chk("pp_last_sof",  bus.out_sof,  1);

      // Restart mid-frame: held nibble dropped, FIFO kept
      do_reset();
      step(0, 0, 0, 0, 0);
      step(1, 4'h1, 1, 0, 0);
      step(1, 4'h2, 1, 0, 0);
      step(1, 4'h3, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 4'hA, 1, 0, 0);
      step(1, 4'hB, 1, 0, 0);
      chk("rs_level", fifo_level, 2);
      chk("rs_head",  bus.out_data, 8'h21);
      step(0, 0, 1, 1, 0);
      chk("rs_data", bus.out_data, 8'hBA);
      chk("rs_sof",  bus.out_sof,  1);
      chk("rs_eol",  bus.out_eol,  0);

      // Reset mid-frame with two bytes queued
      do_reset();
      step(0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(1, 4'(i), 1, 0, 0);
      chk("rm_level_pre", fifo_level, 2);
      step(0, 0, 1, 0, 1);
      chk("rm_valid", bus.out_valid, 0);
      chk("rm_level", fifo_level,    0);
      chk("rm_ovf",   overflow,      0);

      // Randomized traffic against the model
      do_reset();
      run_r = 0;
      rdy_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) rdy_pct = $urandom_range(10, 100);
         if ($urandom_range(0, 60) == 0) run_r = ~run_r;
         step(($urandom_range(0, 3) != 0), 4'($urandom), run_r,
              ($urandom_range(1, 100) <= rdy_pct), ($urandom_range(0, 700) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
